// File: rtl/up_down_sweep_ctrl.sv
// Triangular sweep sequencer: drives a BITS-wide counter lo->hi->lo with a
// programmable dwell at each end, repeated reps times, then pulses done.
module up_down_sweep_ctrl #(
    parameter int BITS       = 4,
    parameter int REP_BITS   = 4,
    parameter int DWELL_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [BITS-1:0]       lo,
    input  logic [BITS-1:0]       hi,
    input  logic [REP_BITS-1:0]   reps,
    input  logic [DWELL_BITS-1:0] dwell,
    output logic [BITS-1:0]       count,
    output logic                  up,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE, UP, DWELL_HI, DOWN, DWELL_LO, DONE
    } state_t;

    state_t                state, state_nxt;
    logic [BITS-1:0]       count_nxt;
    logic [BITS-1:0]       lo_l, lo_nxt;
    logic [BITS-1:0]       hi_l, hi_nxt;
    logic [DWELL_BITS-1:0] dwell_l, dwell_nxt;
    logic [DWELL_BITS-1:0] dcnt, dcnt_nxt;
    logic [REP_BITS-1:0]   rcnt, rcnt_nxt;
    logic                  err_nxt;
    logic                  active;

    assign active = (state == UP) || (state == DWELL_HI) ||
                    (state == DOWN) || (state == DWELL_LO);
    assign busy   = active;
    assign done   = (state == DONE);
    assign up     = !((state == DOWN) || (state == DWELL_LO));

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        lo_nxt    = lo_l;
        hi_nxt    = hi_l;
        dwell_nxt = dwell_l;
        dcnt_nxt  = dcnt;
        rcnt_nxt  = rcnt;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                // abort outranks start even while idle: nothing is accepted
                if (start && !abort) begin
                    if (lo > hi) begin
                        err_nxt = 1'b1;
                    end else begin
                        lo_nxt    = lo;
                        hi_nxt    = hi;
                        dwell_nxt = dwell;
                        rcnt_nxt  = reps;
                        count_nxt = lo;
                        state_nxt = (reps == '0) ? DONE : UP;
                    end
                end
            end
            UP: begin
                if (count == hi_l) begin
                    state_nxt = DWELL_HI;
                    dcnt_nxt  = dwell_l;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            DWELL_HI: begin
                if (dcnt == '0) state_nxt = DOWN;
                else            dcnt_nxt  = dcnt - 1'b1;
            end
            DOWN: begin
                if (count == lo_l) begin
                    state_nxt = DWELL_LO;
                    dcnt_nxt  = dwell_l;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
            DWELL_LO: begin
                if (dcnt != '0) begin
                    dcnt_nxt = dcnt - 1'b1;
                end else if (rcnt == REP_BITS'(1)) begin
                    state_nxt = DONE;
                end else begin
                    rcnt_nxt  = rcnt - 1'b1;
                    state_nxt = UP;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // abort freezes count where it stands; no done is produced
        if (abort && active) begin
            state_nxt = IDLE;
            count_nxt = count;
            dcnt_nxt  = dcnt;
            rcnt_nxt  = rcnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            count   <= '0;
            lo_l    <= '0;
            hi_l    <= '0;
            dwell_l <= '0;
            dcnt    <= '0;
            rcnt    <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            lo_l    <= lo_nxt;
            hi_l    <= hi_nxt;
            dwell_l <= dwell_nxt;
            dcnt    <= dcnt_nxt;
            rcnt    <= rcnt_nxt;
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_up_down_sweep_ctrl.sv
// Scoreboard bench: a waveform-level model queues the expected outputs of each
// cycle; a monitor pops and compares them against the DUT every cycle.
module tb_up_down_sweep_ctrl;

    typedef struct packed {
        logic [3:0] c;
        logic       u;
        logic       b;
        logic       d;
        logic       e;
    } out_t;

    logic       clk = 1'b0;
    logic       reset_n, start, abort;
    logic [3:0] lo, hi, reps, dwell;
    logic [3:0] count;
    logic       up, busy, done, err;

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];
    out_t plan[$];
    out_t cur;

    up_down_sweep_ctrl #(.BITS(4), .REP_BITS(4), .DWELL_BITS(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .lo(lo), .hi(hi), .reps(reps), .dwell(dwell),
        .count(count), .up(up), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Whole sweep as a list of per-cycle outputs, straight from the sweep shape
    task automatic build_plan(input int l, input int h, input int r, input int d);
        plan.delete();
        for (int k = 0; k < r; k++) begin
            for (int v = l; v <= h; v++)  plan.push_back('{4'(v), 1'b1, 1'b1, 1'b0, 1'b0});
            for (int j = 0; j <= d; j++)  plan.push_back('{4'(h), 1'b1, 1'b1, 1'b0, 1'b0});
            for (int v = h; v >= l; v--)  plan.push_back('{4'(v), 1'b0, 1'b1, 1'b0, 1'b0});
            for (int j = 0; j <= d; j++)  plan.push_back('{4'(l), 1'b0, 1'b1, 1'b0, 1'b0});
        end
        plan.push_back('{4'(l), 1'b1, 1'b0, 1'b1, 1'b0});
    endtask

    // Apply inputs for the next edge, predict the outputs after it, wait the edge
    task automatic step(input logic rn, input logic st, input logic ab,
                        input logic [3:0] l, input logic [3:0] h,
                        input logic [3:0] r, input logic [3:0] d);
        out_t nxt;
        reset_n = rn; start = st; abort = ab;
        lo = l; hi = h; reps = r; dwell = d;
        if (!rn) begin
            plan.delete();
            nxt = '{4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        end else if (cur.b && ab) begin
            plan.delete();
            nxt = '{cur.c, 1'b1, 1'b0, 1'b0, 1'b0};
        end else if (plan.size() > 0) begin
            nxt = plan.pop_front();
        end else if (!cur.d && st && !ab) begin
            if (l > h) begin
                nxt = '{cur.c, 1'b1, 1'b0, 1'b0, 1'b1};
            end else begin
                build_plan(int'(l), int'(h), int'(r), int'(d));
                nxt = plan.pop_front();
            end
        end else begin
            nxt = '{cur.c, 1'b1, 1'b0, 1'b0, 1'b0};
        end
        cur = nxt;
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic go(input logic [3:0] l, input logic [3:0] h,
                      input logic [3:0] r, input logic [3:0] d);
        step(1'b1, 1'b1, 1'b0, l, h, r, d);
    endtask

    initial begin : monitor
        out_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({count, up, busy, done, err} !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got count=%0d up=%b busy=%b done=%b err=%b, expected count=%0d up=%b busy=%b done=%b err=%b",
                             $time, count, up, busy, done, err, e.c, e.u, e.b, e.d, e.e);
                end
            end
        end
    end

    initial begin : stim
        int n;
        cur = '{4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        // reset
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        idle(2);
        // basic sweep
        go(4'd2, 4'd4, 4'd1, 4'd0);
        idle(12);
        // reset mid-sweep, then a normal start
        go(4'd0, 4'd15, 4'd1, 4'd0);
        idle(6);
        step(1'b0, 1'b1, 1'b0, 4'd3, 4'd9, 4'd2, 4'd1);
        step(1'b0, 1'b0, 1'b0, 4'd3, 4'd9, 4'd2, 4'd1);
        go(4'd1, 4'd3, 4'd1, 4'd1);
        idle(14);
        // full-range dwell and repeats
        go(4'd0, 4'd15, 4'd3, 4'd5);
        idle(138);
        // degenerate cases
        go(4'd7, 4'd7, 4'd2, 4'd0);
        idle(11);
        go(4'd5, 4'd12, 4'd0, 4'd3);
        idle(3);
        go(4'd9, 4'd3, 4'd1, 4'd0);
        idle(3);
        // abort during DOWN at count 11
        go(4'd0, 4'd15, 4'd1, 4'd0);
        n = 0;
        while (!(cur.b && !cur.u && cur.c == 4'd11) && n < 200) begin
            idle(1);
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL abort_setup never reached count=11 in DOWN within 200 cycles");
        end
        step(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        idle(4);
        // start while busy is ignored
        go(4'd2, 4'd6, 4'd1, 4'd1);
        for (int i = 0; i < 8; i++) go(4'd0, 4'd1, 4'd0, 4'd0);
        idle(12);
        // start together with abort in IDLE
        step(1'b1, 1'b1, 1'b1, 4'd1, 4'd5, 4'd1, 4'd0);
        idle(3);
        // randomized traffic with config churning every cycle
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] l, h;
            l = 4'($urandom);
            h = 4'($urandom);
            if ($urandom_range(0, 3) != 0 && l > h) begin
                l = l ^ h; h = l ^ h; l = l ^ h;
            end
            step($urandom_range(0, 499) != 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 59) == 0,
                 l, h, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
        end
        idle(2);
        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
